// File: rtl/instruction_encoder_pkg.sv
// Shared types, field widths and micro-instruction encoders for instruction_encoder.
// The GO_PEND state exists only when INSTRUCTION_ENCODER_AUTO_GO_EN is defined.
package instruction_encoder_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned WR_ADDR_W = 14;
  localparam int unsigned WR_DATA_W = 16;
  localparam int unsigned RD_ADDR_W = 14;

  typedef enum logic [1:0] {
    OP_WRITE        = 2'b00,
    OP_READ         = 2'b01,
    OP_GO           = 2'b10,
    CMD_WRITE_BURST = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBurst
`ifdef INSTRUCTION_ENCODER_AUTO_GO_EN
    , StGoPend
`endif
  } enc_state_e;

  function automatic logic [INSTR_W-1:0] enc_write(input logic [WR_ADDR_W-1:0] addr,
                                                   input logic [WR_DATA_W-1:0] data);
    return {OP_WRITE, addr, data};
  endfunction

  function automatic logic [INSTR_W-1:0] enc_read(input logic [RD_ADDR_W-1:0] start_addr,
                                                  input logic [RD_ADDR_W-1:0] end_addr);
    return {OP_READ, 1'b0, start_addr, 1'b0, end_addr};
  endfunction

  function automatic logic [INSTR_W-1:0] enc_go();
    return {OP_GO, 30'd0};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous show-ahead FIFO: pop_data always shows the head entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/instruction_encoder.sv
// Encodes host commands into 32-bit micro-instructions and queues them for the decoder.
// Define INSTRUCTION_ENCODER_AUTO_GO_EN to follow every valid READ with an automatic GO.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned BURST_LEN_W = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [WR_ADDR_W-1:0]          cmd_addr,
  input  logic [RD_ADDR_W-1:0]          cmd_end_addr,
  input  logic [WR_DATA_W-1:0]          cmd_data,
  input  logic [BURST_LEN_W-1:0]        cmd_len,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [INSTR_W-1:0]            instr,
  output logic                          cmd_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  enc_state_e             state_q, state_d;
  logic [WR_ADDR_W-1:0]   burst_addr_q, burst_addr_d;
  logic [BURST_LEN_W-1:0] remain_q, remain_d;
  logic                   err_q, err_d;
  logic                   ready_en_q;
  logic                   accept, push, fifo_full, fifo_empty;
  logic [INSTR_W-1:0]     push_data;

  assign accept = cmd_valid & cmd_ready;

  // ready_en_q holds cmd_ready low until the first clock after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      burst_addr_q <= '0;
      remain_q     <= '0;
      err_q        <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      remain_q     <= remain_d;
      err_q        <= err_d;
      ready_en_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    remain_d     = remain_q;
    err_d        = 1'b0;
    push         = 1'b0;
    push_data    = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_op_e'(cmd_op))
            OP_WRITE: begin
              push      = 1'b1;
              push_data = enc_write(cmd_addr, cmd_data);
            end
            OP_GO: begin
              push      = 1'b1;
              push_data = enc_go();
            end
            OP_READ: begin
              if (cmd_end_addr >= cmd_addr) begin
                push      = 1'b1;
                push_data = enc_read(cmd_addr, cmd_end_addr);
`ifdef INSTRUCTION_ENCODER_AUTO_GO_EN
                state_d   = StGoPend;
`endif
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_WRITE_BURST: begin
              if (cmd_len == '0) begin
                err_d = 1'b1;
              end else begin
                push      = 1'b1;
                push_data = enc_write(cmd_addr, cmd_data);
                if (cmd_len != BURST_LEN_W'(1)) begin
                  burst_addr_d = cmd_addr + WR_ADDR_W'(1);
                  remain_d     = cmd_len - BURST_LEN_W'(1);
                  state_d      = StBurst;
                end
              end
            end
            default: ;
          endcase
        end
      end
      StBurst: begin
        // only cmd_data is meaningful on burst beats; address wraps modulo 2^14
        if (accept) begin
          push         = 1'b1;
          push_data    = enc_write(burst_addr_q, cmd_data);
          burst_addr_d = burst_addr_q + WR_ADDR_W'(1);
          remain_d     = remain_q - BURST_LEN_W'(1);
          if (remain_q == BURST_LEN_W'(1)) state_d = StIdle;
        end
      end
`ifdef INSTRUCTION_ENCODER_AUTO_GO_EN
      StGoPend: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = enc_go();
          state_d   = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready   = ready_en_q & ~fifo_full & ((state_q == StIdle) | (state_q == StBurst));
    busy        = (state_q != StIdle) | ~fifo_empty;
    cmd_err     = err_q;
    instr_valid = ~fifo_empty;
  end

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (instr_valid & instr_ready),
    .pop_data  (instr),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [13:0] cmd_addr = '0;
  logic [13:0] cmd_end_addr = '0;
  logic [15:0] cmd_data = '0;
  logic [7:0]  cmd_len = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic        cmd_err;
  logic        busy;
  logic [2:0]  fifo_count;

  instruction_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_end_addr (cmd_end_addr),
    .cmd_data     (cmd_data),
    .cmd_len      (cmd_len),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .cmd_err      (cmd_err),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: expected stream contents plus open-burst bookkeeping
  logic [31:0] exp_q[$];
  bit          m_burst, m_gopend, m_rdy_en, m_err;
  logic [13:0] m_baddr;
  int          m_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    return m_rdy_en && (exp_q.size() < 4) && !m_gopend;
  endfunction

  task automatic compare_outputs();
    check_eq("cmd_ready", cmd_ready, model_ready());
    check_eq("instr_valid", instr_valid, exp_q.size() != 0);
    check_eq("fifo_count", fifo_count, exp_q.size());
    check_eq("busy", busy, m_burst || m_gopend || exp_q.size() != 0);
    check_eq("cmd_err", cmd_err, m_err);
    if (exp_q.size() != 0) check_eq("instr", instr, exp_q[0]);
  endtask

  // one clock: drive at negedge, check, predict, advance to next negedge
  task automatic cyc(input bit v, input logic [1:0] op, input logic [13:0] a,
                     input logic [13:0] e, input logic [15:0] d, input logic [7:0] l,
                     input bit r);
    bit          acc, pop, p, new_err;
    logic [31:0] pw;
    cmd_valid = v; cmd_op = op; cmd_addr = a; cmd_end_addr = e; cmd_data = d;
    cmd_len = l; instr_ready = r;
    #1;
    compare_outputs();
    acc = v && model_ready();
    pop = (exp_q.size() != 0) && r;
    p = 0; pw = '0; new_err = 0;
    if (m_gopend) begin
      if (exp_q.size() < 4) begin p = 1; pw = 32'h8000_0000; m_gopend = 0; end
    end else if (m_burst) begin
      if (acc) begin
        p = 1; pw = {2'b00, m_baddr, d};
        m_baddr = m_baddr + 14'd1;
        m_left--;
        if (m_left == 0) m_burst = 0;
      end
    end else if (acc) begin
      case (op)
        2'b00: begin p = 1; pw = {2'b00, a, d}; end
        2'b10: begin p = 1; pw = 32'h8000_0000; end
        2'b01: begin
          if (e >= a) begin
            p = 1; pw = {2'b01, 1'b0, a, 1'b0, e};
`ifdef INSTRUCTION_ENCODER_AUTO_GO_EN
            m_gopend = 1;
`endif
          end else new_err = 1;
        end
        default: begin
          if (l == 0) new_err = 1;
          else begin
            p = 1; pw = {2'b00, a, d};
            if (l > 1) begin m_burst = 1; m_baddr = a + 14'd1; m_left = int'(l) - 1; end
          end
        end
      endcase
    end
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (p) exp_q.push_back(pw);
    m_err = new_err;
    m_rdy_en = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 14'h0, 14'h0, 16'h0, 8'h0, r);
  endtask

  task automatic apply_reset();
    #3 rst = 1'b1;
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_cmd_err", cmd_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fifo_count", fifo_count, 0);
    exp_q.delete();
    m_burst = 0; m_gopend = 0; m_rdy_en = 0; m_err = 0; m_left = 0; m_baddr = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    m_burst = 0; m_gopend = 0; m_rdy_en = 0; m_err = 0; m_left = 0; m_baddr = '0;
    @(negedge clk);
    apply_reset();
    idle(1, 1);
    check_eq("ready_after_release", cmd_ready, 1);

    // single write, visible for exactly one cycle when drained
    cyc(1, 2'b00, 14'h0123, 14'h0, 16'hBEEF, 8'd0, 1);
    check_eq("wr_enc", instr, 32'h0123BEEF);
    check_eq("wr_valid", instr_valid, 1);
    idle(1, 1);
    check_eq("wr_valid_once", instr_valid, 0);

    // valid and inverted read ranges
    cyc(1, 2'b01, 14'h0010, 14'h0020, 16'h0, 8'd0, 1);
    check_eq("rd_enc", instr, 32'h4008_0020);
    idle(2, 1);
    cyc(1, 2'b01, 14'h0020, 14'h0010, 16'h0, 8'd0, 1);
    check_eq("rd_err", cmd_err, 1);
    check_eq("rd_err_nopush", instr_valid, 0);
    idle(1, 1);
    check_eq("rd_err_pulse", cmd_err, 0);

    // burst across the address wrap; beat op/addr/len fields are ignored
    cyc(1, 2'b11, 14'h3FFE, 14'h0, 16'h1111, 8'd3, 1);
    check_eq("burst0", instr, 32'h3FFE1111);
    cyc(1, 2'b01, 14'h1234, 14'h0, 16'h2222, 8'd0, 1);
    check_eq("burst1", instr, 32'h3FFF2222);
    cyc(1, 2'b10, 14'h0555, 14'h0, 16'h3333, 8'd9, 1);
    check_eq("burst2_wrap", instr, 32'h0000_3333);
    cyc(1, 2'b11, 14'h0100, 14'h0, 16'h4444, 8'd0, 1);
    check_eq("burst_len0_err", cmd_err, 1);
    idle(2, 1);

    // fill the FIFO with downstream stalled, then drain while still pushing
    for (int i = 0; i < 4; i++) cyc(1, 2'b00, 14'(i + 1), 14'h0, 16'(16'hA000 + i), 8'd0, 0);
    check_eq("full_count", fifo_count, 4);
    check_eq("full_not_ready", cmd_ready, 0);
    for (int i = 0; i < 8; i++) cyc(1, 2'b00, 14'(i + 8), 14'h0, 16'(16'hB000 + i), 8'd0, 1);
    idle(6, 1);

    // reset in the middle of a burst with beats still outstanding
    cyc(1, 2'b11, 14'h0200, 14'h0, 16'hC000, 8'd4, 0);
    cyc(1, 2'b00, 14'h0, 14'h0, 16'hC001, 8'd0, 0);
    apply_reset();
    idle(1, 1);
    cyc(1, 2'b00, 14'h0005, 14'h0, 16'h1234, 8'd0, 1);
    check_eq("post_rst_wr", instr, 32'h0005_1234);
    cyc(1, 2'b00, 14'h0006, 14'h0, 16'h5678, 8'd0, 1);
    check_eq("burst_not_resumed", instr, 32'h0006_5678);
    idle(2, 1);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [13:0] a, e;
      a = ($urandom_range(0, 3) == 0) ? 14'(14'h3FFC + $urandom_range(0, 3)) : 14'($urandom);
      e = ($urandom_range(0, 1) == 0) ? 14'(a + 14'($urandom_range(0, 8))) : 14'($urandom);
      cyc($urandom_range(0, 3) != 0, 2'($urandom), a, e, 16'($urandom),
          8'($urandom_range(0, 4)), $urandom_range(0, 2) != 0);
    end
    idle(12, 1);
    check_eq("drained", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
